modinv_helper_invert_compare: RTL and testbench

MODINV_HELPER_INVERT_COMPARE -- requirements
Module: modinv_helper_invert_compare

---
 rtl/modinv_helper_invert_compare.sv | 65 ++++++
 tb/tb_modinv_helper_invert_compare.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/modinv_helper_invert_compare.sv
// modinv_helper_invert_compare: word-serial u>v, v==1 and parity scan over two operand buffers
module modinv_helper_invert_compare #(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    output logic                        rdy,
    output logic [BUFFER_ADDR_BITS-1:0] u_addr,
    output logic [BUFFER_ADDR_BITS-1:0] v_addr,
    input  logic [31:0]                 u_din,
    input  logic [31:0]                 v_din,
    output logic                        u_gt_v,
    output logic                        v_eq_1,
    output logic                        u_is_even,
    output logic                        v_is_even
);
    localparam int CW = $clog2(BUFFER_NUM_WORDS + 2);
    localparam logic [CW-1:0] CNT_N = CW'(BUFFER_NUM_WORDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUFFER_NUM_WORDS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          gt_q, gt_d, eq1_q, eq1_d, ue_q, ue_d, ve_q, ve_d;
    logic [3:0]    flags_q, flags_d;
    logic          start, fold, first;
    logic [BUFFER_ADDR_BITS-1:0] addr;

    always_comb begin
        start   = cnt_q == '0 && ena;
        fold    = cnt_q >= CW'(2);
        first   = cnt_q == CW'(2);
        cnt_d   = cnt_q == '0 ? CW'(ena) : cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
        addr    = (cnt_q != '0 && cnt_q <= CNT_N) ? BUFFER_ADDR_BITS'(cnt_q - 1'b1) : '0;
        gt_d    = start ? 1'b0 : !fold ? gt_q : u_din > v_din ? 1'b1 : u_din < v_din ? 1'b0 : gt_q;
        eq1_d   = start ? 1'b1 : fold ? eq1_q & (v_din == (first ? 32'd1 : 32'd0)) : eq1_q;
        ue_d    = start ? 1'b0 : first ? ~u_din[0] : ue_q;
        ve_d    = start ? 1'b0 : first ? ~v_din[0] : ve_q;
        // commit uses the _d values so the last word, folded on this same edge, is included
        flags_d = cnt_q == CNT_LAST ? {gt_d, eq1_d, ue_d, ve_d} : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq1_q   <= 1'b0;
            ue_q    <= 1'b0;
            ve_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq1_q   <= eq1_d;
            ue_q    <= ue_d;
            ve_q    <= ve_d;
            flags_q <= flags_d;
        end
    end

    assign rdy = cnt_q == '0;
    assign u_addr = addr;
    assign v_addr = addr;
    assign {u_gt_v, v_eq_1, u_is_even, v_is_even} = flags_q;
endmodule

// File: tb/tb_modinv_helper_invert_compare.sv
// tb_modinv_helper_invert_compare: scoreboard bench with synchronous-RAM operand model
module tb_modinv_helper_invert_compare;
    localparam int N = 9;
    localparam int AW = 4;
    typedef logic [N*32-1:0] wide_t;

    logic          clk = 1'b0, rst = 1'b1, ena = 1'b0;
    logic          rdy, u_gt_v, v_eq_1, u_is_even, v_is_even;
    logic [AW-1:0] u_addr, v_addr;
    logic [31:0]   u_din, v_din;
    logic [31:0]   u_mem [N];
    logic [31:0]   v_mem [N];
    logic [3:0]    exp_q [$];
    logic [3:0]    held = '0;
    int            total = 0, bad = 0;

    modinv_helper_invert_compare #(.BUFFER_NUM_WORDS(N), .BUFFER_ADDR_BITS(AW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rdy(rdy),
        .u_addr(u_addr), .v_addr(v_addr), .u_din(u_din), .v_din(v_din),
        .u_gt_v(u_gt_v), .v_eq_1(v_eq_1), .u_is_even(u_is_even), .v_is_even(v_is_even)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        u_din <= u_addr < AW'(N) ? u_mem[u_addr] : 32'hdeadbeef;
        v_din <= v_addr < AW'(N) ? v_mem[v_addr] : 32'hdeadbeef;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_flags(wide_t u, wide_t v);
        return {u > v, v == wide_t'(1), ~u[0], ~v[0]};
    endfunction

    function automatic wide_t rnd_wide();
        wide_t r;
        for (int i = 0; i < N; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // monitor: latency, address trace, flag hold and scoreboard compare
    int  low = 0;
    bit  prev_rdy = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            low = 0;
            prev_rdy = 1'b1;
            held = '0;
        end else if (!rdy) begin
            low++;
            check("addr_run", u_addr, low <= N ? low - 1 : 0);
            check("addr_eq", v_addr, u_addr);
            check("flags_hold_run", {u_gt_v, v_eq_1, u_is_even, v_is_even}, held);
            prev_rdy = 1'b0;
        end else begin
            check("addr_idle", {u_addr, v_addr}, 0);
            if (!prev_rdy) begin
                check("latency", low, N + 1);
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else held = exp_q.pop_front();
            end
            check("flags", {u_gt_v, v_eq_1, u_is_even, v_is_even}, held);
            low = 0;
            prev_rdy = 1'b1;
        end
    end

    task automatic start(wide_t u, wide_t v, bit hold);
        int w = 0;
        @(negedge clk);
        while (!rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy) check("rdy_timeout", rdy, 1);
        for (int i = 0; i < N; i++) begin
            u_mem[i] = u[i*32 +: 32];
            v_mem[i] = v[i*32 +: 32];
        end
        exp_q.push_back(ref_flags(u, v));
        ena = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ena = 1'b0;
    endtask

    initial begin
        wide_t u, v;
        int w;
        for (int i = 0; i < N; i++) begin
            u_mem[i] = '0;
            v_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_addr", {u_addr, v_addr}, 0);
        check("rst_flags", {u_gt_v, v_eq_1, u_is_even, v_is_even}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        start(wide_t'(5), wide_t'(3), 0);
        start(wide_t'(1) << 64, wide_t'(1) << 64, 0);
        start(wide_t'(2), wide_t'(1), 0);
        start(wide_t'(2), (wide_t'(1) << 256) | wide_t'(1), 0);
        start(wide_t'(32'hFFFFFFFF), wide_t'(1) << 256, 0);

        for (int i = 0; i < 4; i++) start(rnd_wide(), rnd_wide(), i < 3);

        for (int i = 0; i < 24; i++) begin
            u = rnd_wide();
            v = rnd_wide();
            case ($urandom_range(0, 4))
                0: v = u;
                1: v = wide_t'(1);
                2: begin v = u; v[$urandom_range(0, N-1)*32 +: 32] = $urandom; end
                3: begin u = u >> (32 * $urandom_range(1, N-1)); v = v >> (32 * $urandom_range(1, N-1)); end
                default: ;
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start(u, v, 0);
        end

        start(wide_t'(5), wide_t'(3), 0);
        start(rnd_wide(), rnd_wide(), 0);
        check("pre_rst_gt", u_gt_v, 1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_rdy", rdy, 1);
        check("midrun_rst_addr", {u_addr, v_addr}, 0);
        check("midrun_rst_flags", {u_gt_v, v_eq_1, u_is_even, v_is_even}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        start(wide_t'(5), wide_t'(3), 0);
        start(wide_t'(4), wide_t'(1), 0);

        w = 0;
        while ((exp_q.size() != 0 || !rdy) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
